sqrt_sched: RTL and testbench
=============================

SQRT_SCHED -- requirements
Module: sqrt_sched

Interface
REQ-001 Parameter N_REQ, 4, number of requesters sharing one sqrt2 core (2..8).
REQ-002 Parameter TIMEOUT, 32, max WAIT cycles before abort (>=2, <=255).
REQ-003 Reset is synchronous and active-high; one clock.
REQ-004 CLK  input  1  rising-edge clock shared with the core.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 REQ  input  N_REQ  per-requester request level; held until GNT.
REQ-007 OPERAND  input  16*N_REQ  fp16 operand, slice i belongs to requester i.
REQ-008 GNT  output  N_REQ  one-hot, one-cycle accept pulse; operand sampled that cycle.
REQ-009 DONE  output  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
REQ-010 RES_DATA  output  16  result, valid only while any DONE bit is high.
REQ-011 RES_FLAGS  output  3  {IS_NAN, IS_PINF, IS_NINF} captured with RES_DATA.
REQ-012 TIMEOUT_ERR  output  1  high with DONE when the job aborted.
REQ-013 BUSY  output  1  high in every state except IDLE.
REQ-014 CORE_IO  inout  16  core IO_DATA bus.
REQ-015 CORE_ENABLE  output  1  core ENABLE.
REQ-016 CORE_IS_NAN, CORE_IS_PINF, CORE_IS_NINF, CORE_RESULT  input  1 each  core status.

Function
REQ-017 States: IDLE, LOAD, WAIT, RELEASE; encoding from the shared package.
REQ-018 IDLE: if REQ!=0, pulse GNT to the round-robin winner, latch its index and operand, go LOAD; else stay.
REQ-019 Round-robin: search starts at pointer; pointer becomes winner+1 (mod N_REQ) on each grant.
REQ-020 LOAD: CORE_ENABLE=1, CORE_IO driven with latched operand; exactly one cycle; go WAIT, wait counter=0.
REQ-021 WAIT: CORE_ENABLE=1, CORE_IO released to Z (turnaround cycle guaranteed before core drives); counter increments each cycle.
REQ-022 Capture condition in WAIT: counter>=1 and CORE_RESULT=1; latch CORE_IO and three flags, go RELEASE.
REQ-023 RELEASE: CORE_ENABLE=0 (clears core loaded/counter); DONE[index]=1, RES_DATA/RES_FLAGS from capture; go IDLE.
REQ-024 Minimum latency: GNT in cycle t, DONE in cycle t+4; next GNT no earlier than t+5.
REQ-025 Controller never drives CORE_IO outside LOAD; no bus contention in any state.
REQ-026 REQ of the active requester during BUSY is ignored; its arbitration restarts in IDLE.
REQ-027 DONE, GNT, TIMEOUT_ERR are zero in every cycle not stated above.

Reset
REQ-028 RST in any state: next cycle state=IDLE, pointer=0, CORE_ENABLE=0, CORE_IO=Z, GNT=DONE=0, RES_DATA=0, RES_FLAGS=0, TIMEOUT_ERR=0, BUSY=0.
REQ-029 RST mid-job drops the job silently: no DONE is issued for it.

Configuration
REQ-030 Macro SQRT_SCHED_TIMEOUT_EN.
REQ-031 Defined: WAIT with counter==TIMEOUT and no capture goes RELEASE with RES_DATA=16'hFE00, RES_FLAGS=3'b100, TIMEOUT_ERR=1.
REQ-032 Not defined: capture occurs unconditionally at counter==1 (CORE_RESULT ignored); TIMEOUT_ERR tied 0; TIMEOUT parameter unused.

Structure
REQ-033 Package sqrt_sched_pkg holds state enum, FP16_QNAN=16'hFE00, flag-vector bit positions.
REQ-034 Sub-module sqrt_rr_arb: combinational N_REQ round-robin picker (REQ, pointer -> one-hot winner, index, valid).
REQ-035 Top instantiates sqrt_rr_arb only; the sqrt2 core is instantiated by the bench/integration level.

Verification
REQ-036 REQ=0001, OPERAND0=16'h0000 at t -> GNT=0001 at t, DONE=0001 at t+4, RES_DATA=16'h0000, RES_FLAGS=000.
REQ-037 REQ=0010, operand 16'hBC00 (-1.0) -> DONE=0010, RES_DATA=16'hFE00, RES_FLAGS=100.
REQ-038 Operand 16'h7C01 -> RES_DATA=16'h7E01, flags 100; operand 16'h7C00 -> RES_DATA=16'h7C00, flags 010.
REQ-039 REQ=1111 held, all operands 16'h0000 -> GNT order 0,1,2,3,0, spacing 5 cycles, never two GNT bits high.
REQ-040 With SQRT_SCHED_TIMEOUT_EN, operand 16'h3C00 (core RESULT=0) -> DONE at t+3+TIMEOUT, RES_DATA=16'hFE00, TIMEOUT_ERR=1.
REQ-041 RST pulsed during WAIT -> next cycle CORE_ENABLE=0, BUSY=0, no DONE; next request grants requester 0 first.

Source files
------------

// File: rtl/sqrt_sched_pkg.sv
// Shared types and constants for the sqrt2-core scheduler: FSM encoding,
// the canonical fp16 quiet NaN and the bit layout of the result flag vector.
package sqrt_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [15:0] FP16_QNAN = 16'hFE00;

    // Flag vector is {IS_NAN, IS_PINF, IS_NINF}
    localparam int FLAG_W    = 3;
    localparam int FLAG_NAN  = 2;
    localparam int FLAG_PINF = 1;
    localparam int FLAG_NINF = 0;

    localparam logic [FLAG_W-1:0] FLAGS_ABORT = FLAG_W'(1) << FLAG_NAN;

endpackage

// File: rtl/sqrt_rr_arb.sv
// Combinational round-robin picker: the first requester at or after the
// pointer (wrapping) wins; outputs its index, a one-hot vector and a valid bit.
module sqrt_rr_arb
    import sqrt_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0] o_index,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest hit is written last
    always_comb begin
        w_cand  = '0;
        o_valid = 1'b0;
        o_index = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % N_REQ);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_index = w_cand;
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
        assign o_onehot[gi] = o_valid && (o_index == IDX_W'(gi));
    end

endmodule

// File: rtl/sqrt_sched.sv
// Shares one sqrt2 core among N_REQ requesters (IDLE/LOAD/WAIT/RELEASE).
// Optional abort-on-timeout is enabled by defining SQRT_SCHED_TIMEOUT_EN.
module sqrt_sched
    import sqrt_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_REQ-1:0]    i_req,
    input  logic [16*N_REQ-1:0] i_operand,
    output logic [N_REQ-1:0]    o_gnt,
    output logic [N_REQ-1:0]    o_done,
    output logic [15:0]         o_res_data,
    output logic [FLAG_W-1:0]   o_res_flags,
    output logic                o_timeout_err,
    output logic                o_busy,
    inout  wire  [15:0]         io_core_io,
    output logic                o_core_enable,
    input  logic                i_core_is_nan,
    input  logic                i_core_is_pinf,
    input  logic                i_core_is_ninf,
    input  logic                i_core_result
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic [15:0]        r_operand;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_res_data;
    logic [FLAG_W-1:0]  r_res_flags;
    logic               r_timeout;

    logic [N_REQ-1:0]   w_arb_onehot;
    logic [IDX_W-1:0]   w_arb_index;
    logic               w_arb_valid;
    logic [IDX_W-1:0]   w_ptr_next;
    logic               w_drive_bus;
    logic               w_capture;
    logic               w_abort;
    logic [15:0]        w_ops [N_REQ];

    sqrt_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_onehot (w_arb_onehot),
        .o_index  (w_arb_index),
        .o_valid  (w_arb_valid)
    );

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ops
        assign w_ops[gi]  = i_operand[gi*16 +: 16];
        assign o_done[gi] = (r_state == ST_RELEASE) && (r_idx == IDX_W'(gi));
    end

    assign w_ptr_next = (w_arb_index == IDX_W'(N_REQ - 1)) ? '0 : w_arb_index + 1'b1;

`ifdef SQRT_SCHED_TIMEOUT_EN
    assign w_capture = (r_state == ST_WAIT) && (r_cnt >= CNT_W'(1)) && i_core_result;
    assign w_abort   = (r_state == ST_WAIT) && !w_capture && (r_cnt == CNT_W'(TIMEOUT));
`else
    // Core latency is fixed here, so its RESULT strobe is not consulted
    logic w_unused_result;
    assign w_unused_result = i_core_result;
    assign w_capture = (r_state == ST_WAIT) && (r_cnt == CNT_W'(1));
    assign w_abort   = 1'b0;
`endif

    always_comb begin
        w_state_next  = r_state;
        o_gnt         = '0;
        o_core_enable = 1'b0;
        w_drive_bus   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    o_gnt        = w_arb_onehot;
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_core_enable = 1'b1;
                w_drive_bus   = 1'b1;
                w_state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                o_core_enable = 1'b1;
                if (w_capture || w_abort) w_state_next = ST_RELEASE;
            end
            ST_RELEASE: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_operand   <= '0;
            r_cnt       <= '0;
            r_res_data  <= '0;
            r_res_flags <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_idx     <= w_arb_index;
                        r_operand <= w_ops[w_arb_index];
                        r_ptr     <= w_ptr_next;
                        r_timeout <= 1'b0;
                    end
                end
                ST_LOAD: r_cnt <= '0;
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_capture) begin
                        r_res_data  <= io_core_io;
                        r_res_flags <= {i_core_is_nan, i_core_is_pinf, i_core_is_ninf};
                    end else if (w_abort) begin
                        r_res_data  <= FP16_QNAN;
                        r_res_flags <= FLAGS_ABORT;
                        r_timeout   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Only LOAD drives the shared bus; every other state leaves it to the core
    assign io_core_io    = w_drive_bus ? r_operand : 16'hzzzz;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_timeout_err = (r_state == ST_RELEASE) && r_timeout;
    assign o_res_data    = r_res_data;
    assign o_res_flags   = r_res_flags;

endmodule

// File: tb/tb_sqrt_sched.sv
// Directed bench for sqrt_sched with a small behavioural sqrt2 core model;
// the abort test runs only when SQRT_SCHED_TIMEOUT_EN is defined.
module tb_sqrt_sched;
    import sqrt_sched_pkg::*;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N_REQ-1:0]    req = '0;
    logic [16*N_REQ-1:0] operand = '0;
    wire  [N_REQ-1:0]    gnt;
    wire  [N_REQ-1:0]    done;
    wire  [15:0]         res_data;
    wire  [2:0]          res_flags;
    wire                 terr;
    wire                 busy;
    wire                 core_en;
    tri   [15:0]         core_io;
    logic                core_nan, core_pinf, core_ninf, core_result;

    int n_cmp = 0;
    int n_err = 0;

    sqrt_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req          (req),
        .i_operand      (operand),
        .o_gnt          (gnt),
        .o_done         (done),
        .o_res_data     (res_data),
        .o_res_flags    (res_flags),
        .o_timeout_err  (terr),
        .o_busy         (busy),
        .io_core_io     (core_io),
        .o_core_enable  (core_en),
        .i_core_is_nan  (core_nan),
        .i_core_is_pinf (core_pinf),
        .i_core_is_ninf (core_ninf),
        .i_core_result  (core_result)
    );

    always #5 clk = ~clk;

    // sqrt2 core model: loads operand on first enabled cycle, drives result one
    // cycle after that (leaving a turnaround cycle), clears when ENABLE drops.
    logic        core_loaded;
    logic [7:0]  core_cnt;
    logic [15:0] core_op;
    logic        core_stall = 1'b0;
    logic [15:0] core_val;
    logic [2:0]  core_flg;
    logic        core_drive;

    always @(posedge clk) begin
        if (rst || !core_en) begin
            core_loaded <= 1'b0;
            core_cnt    <= 8'd0;
        end else if (!core_loaded) begin
            core_loaded <= 1'b1;
            core_op     <= core_io;
            core_cnt    <= 8'd0;
        end else if (core_cnt != 8'hFF) begin
            core_cnt <= core_cnt + 8'd1;
        end
    end

    always_comb begin
        core_val = 16'hFE00;
        core_flg = 3'b100;
        case (core_op)
            16'h0000: begin core_val = 16'h0000; core_flg = 3'b000; end
            16'h8000: begin core_val = 16'h8000; core_flg = 3'b000; end
            16'h3C00: begin core_val = 16'h3C00; core_flg = 3'b000; end
            16'h4400: begin core_val = 16'h4000; core_flg = 3'b000; end
            16'h7C00: begin core_val = 16'h7C00; core_flg = 3'b010; end
            16'h7C01: begin core_val = 16'h7E01; core_flg = 3'b100; end
            default:  ;
        endcase
    end

    assign core_drive  = core_en && core_loaded && (core_cnt >= 8'd1) && !core_stall;
    assign core_io     = core_drive ? core_val : 16'hzzzz;
    assign core_result = core_drive;
    assign core_nan    = core_drive && core_flg[2];
    assign core_pinf   = core_drive && core_flg[1];
    assign core_ninf   = core_drive && core_flg[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_core_en", 32'(core_en), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_flags", 32'(res_flags), 32'd0);
        check("rst_terr", 32'(terr), 32'd0);
        rst = 1'b0;
        $display("reset applied");
    endtask

    task automatic run_job(input int idx, input logic [15:0] op, input logic [15:0] exp_data,
                           input logic [2:0] exp_flags, input int exp_lat, input logic exp_terr);
        int lat;
        int gnt_seen;
        lat = 0;
        gnt_seen = 0;
        @(negedge clk);
        operand[idx*16 +: 16] = op;
        req = N_REQ'(1) << idx;
        #1;
        check("gnt", 32'(gnt), 32'(1) << idx);
        check("busy_idle", 32'(busy), 32'd0);
        for (int k = 1; k <= TIMEOUT + 10; k++) begin
            @(negedge clk);
            if (gnt != '0) gnt_seen++;
            if (done != '0) begin
                lat = k;
                break;
            end
            if (k == 1) begin
                check("load_en", 32'(core_en), 32'd1);
                check("load_busy", 32'(busy), 32'd1);
                // another requester pulls REQ while busy: must not be granted
                req = N_REQ'(1) << ((idx + 2) % N_REQ);
            end
            if (k == 3) req = '0;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("gnt_while_busy", 32'(gnt_seen), 32'd0);
        if (lat != 0) begin
            check("done", 32'(done), 32'(1) << idx);
            check("res_data", 32'(res_data), 32'(exp_data));
            check("res_flags", 32'(res_flags), 32'(exp_flags));
            check("terr", 32'(terr), 32'(exp_terr));
            check("release_en", 32'(core_en), 32'd0);
        end
        @(negedge clk);
        check("post_busy", 32'(busy), 32'd0);
        check("post_done", 32'(done), 32'd0);
        $display("job req=%0d op=%h data=%h flags=%b lat=%0d terr=%b",
                 idx, op, res_data, res_flags, lat, terr);
    endtask

    task automatic drain_done(input logic [N_REQ-1:0] exp_done);
        int seen;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (done != '0) begin
                seen = 1;
                check("drain_done", 32'(done), 32'(exp_done));
            end
        end
        check("drain_seen", 32'(seen), 32'd1);
    endtask

    int rr_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        int ngr;
        int last_c;
        int last_idx;
        int dcnt;

        do_reset();

        run_job(0, 16'h0000, 16'h0000, 3'b000, 4, 1'b0);
        run_job(1, 16'hBC00, 16'hFE00, 3'b100, 4, 1'b0);
        run_job(2, 16'h7C01, 16'h7E01, 3'b100, 4, 1'b0);
        run_job(3, 16'h7C00, 16'h7C00, 3'b010, 4, 1'b0);
        run_job(0, 16'h4400, 16'h4000, 3'b000, 4, 1'b0);
        run_job(1, 16'h8000, 16'h8000, 3'b000, 4, 1'b0);

        // Round robin with all four requesting continuously
        do_reset();
        @(negedge clk);
        operand = '0;
        req = '1;
        #1;
        ngr = 0;
        last_c = 0;
        last_idx = 0;
        for (int c = 0; c < 40 && ngr < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (done != '0) check("rr_done", 32'(done), 32'(1) << last_idx);
            if (gnt != '0) begin
                check("rr_onehot", 32'($onehot(gnt)), 32'd1);
                check("rr_order", 32'(gnt), 32'(1) << rr_exp[ngr]);
                if (ngr > 0) check("rr_spacing", 32'(c - last_c), 32'd5);
                $display("rr grant #%0d gnt=%b cycle=%0d", ngr, gnt, c);
                last_c = c;
                last_idx = rr_exp[ngr];
                ngr++;
            end
        end
        check("rr_count", 32'(ngr), 32'd5);
        @(negedge clk);
        req = '0;
        drain_done(4'b0001);

        // Reset during WAIT drops the job and returns the pointer to 0
        run_job(2, 16'h4400, 16'h4000, 3'b000, 4, 1'b0);
        @(negedge clk);
        operand[1*16 +: 16] = 16'h3C00;
        req = 4'b0010;
        #1;
        check("mid_gnt", 32'(gnt), 32'h2);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        check("mid_busy_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_core_en", 32'(core_en), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done != '0) dcnt++;
        end
        check("mid_no_done", 32'(dcnt), 32'd0);
        operand = '0;
        req = '1;
        #1;
        check("mid_first_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        req = '0;
        drain_done(4'b0001);
        $display("mid-job reset sequence complete");

`ifdef SQRT_SCHED_TIMEOUT_EN
        core_stall = 1'b1;
        run_job(0, 16'h3C00, 16'hFE00, 3'b100, 3 + TIMEOUT, 1'b1);
        core_stall = 1'b0;
        run_job(1, 16'h3C00, 16'h3C00, 3'b000, 4, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
